// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add is split into STAGES chunks of CHUNK bits. Stage k ripples
// its chunk using the carry registered by stage k-1 and carries the already
// finished low chunks, the unprocessed operand bits and the carry forward.
// The pipeline is a stall-able shift register: every stage advances together
// when the output slot is empty or being consumed.
//
// Handshake: a beat moves on either port when valid && ready are both high at
// a rising clock edge. in_ready = !out_valid || out_ready. While out_valid is
// high and out_ready is low, out/cout (and ovf) hold their values.
//
// Optional build macro: RCA_PIPE_OVERFLOW_EN adds the ovf output (signed
// two's-complement overflow of the final result, piped with out/cout).
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout
`ifdef RCA_PIPE_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  // Per-stage registers: slot valid, partial sum, operand bits, carry out.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_c     [STAGES];

  // What each stage sees as its input (predecessor registers or the ports).
  logic             w_in_v   [STAGES];
  logic [WIDTH-1:0] w_in_sum [STAGES];
  logic [WIDTH-1:0] w_in_a   [STAGES];
  logic [WIDTH-1:0] w_in_b   [STAGES];
  logic             w_in_c   [STAGES];

  // What each stage will register on an advance.
  logic [CHUNK:0]   w_chunk    [STAGES];
  logic [WIDTH-1:0] w_next_sum [STAGES];
  logic             w_next_c   [STAGES];

  logic             w_adv;

  // The whole pipe moves when the output slot is free or being drained.
  assign w_adv    = !r_valid[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  // Stage inputs and per-chunk ripple add.
  always_comb begin
    // Stage 0 conditions the operands: subtract is A + ~B + ~borrow.
    w_in_v[0]   = in_valid;
    w_in_sum[0] = '0;
    w_in_a[0]   = in0;
    w_in_b[0]   = sub ? ~in1 : in1;
    w_in_c[0]   = cin ^ sub;
    for (int k = 1; k < STAGES; k++) begin
      w_in_v[k]   = r_valid[k-1];
      w_in_sum[k] = r_sum[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_c[k]   = r_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_in_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, w_in_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_in_c[k]};
      // Low chunks pass through untouched; only this stage's chunk is filled.
      w_next_sum[k]                    = w_in_sum[k];
      w_next_sum[k][k*CHUNK +: CHUNK]  = w_chunk[k][CHUNK-1:0];
      w_next_c[k]                      = w_chunk[k][CHUNK];
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_c[k]     <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_in_v[k];
        r_sum[k]   <= w_next_sum[k];
        r_a[k]     <= w_in_a[k];
        r_b[k]     <= w_in_b[k];
        r_c[k]     <= w_next_c[k];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];

`ifdef RCA_PIPE_OVERFLOW_EN
  // Carry into the MSB equals a ^ b ^ sum at that bit; xor with carry-out.
  logic w_next_ovf;
  logic r_ovf;

  assign w_next_ovf = w_in_a[STAGES-1][WIDTH-1] ^ w_in_b[STAGES-1][WIDTH-1]
                    ^ w_next_sum[STAGES-1][WIDTH-1] ^ w_next_c[STAGES-1];

  // Overflow flag rides in the last stage alongside out/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_next_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: scoreboard bench for rca_pipe (16/4 main instance plus two
// 4-bit instances, 2 and 4 stages, swept over every operand combination).
module tb_rca_pipe;

`ifdef RCA_PIPE_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (16/4) ----------------
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] in0, in1, out;

  rca_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout)
`ifdef RCA_PIPE_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  // ---------------- sweep DUTs (4/2 and 4/4) ----------------
  logic       sw_valid, sw_cin, sw_sub;
  logic [3:0] sw_a, sw_b;
  logic       s2_in_ready, s2_out_valid, s2_cout, s2_ovf;
  logic       s4_in_ready, s4_out_valid, s4_cout, s4_ovf;
  logic [3:0] s2_out, s4_out;

  rca_pipe #(.WIDTH(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s2_in_ready),
    .in0(sw_a), .in1(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(s2_out_valid), .out_ready(1'b1), .out(s2_out), .cout(s2_cout)
`ifdef RCA_PIPE_OVERFLOW_EN
    , .ovf(s2_ovf)
`endif
  );

  rca_pipe #(.WIDTH(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s4_in_ready),
    .in0(sw_a), .in1(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(s4_out_valid), .out_ready(1'b1), .out(s4_out), .cout(s4_cout)
`ifdef RCA_PIPE_OVERFLOW_EN
    , .ovf(s4_ovf)
`endif
  );

`ifndef RCA_PIPE_OVERFLOW_EN
  assign ovf    = 1'b0;
  assign s2_ovf = 1'b0;
  assign s4_ovf = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  logic [5:0]  q2[$];
  logic [5:0]  q4[$];
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  // Returns {ovf, cout, out[31:0]}.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic c,
                                            input logic s);
    logic [63:0] mask, bp, tot;
    logic [31:0] o;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bp   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    tot  = {32'd0, a} + bp + {63'd0, c ^ s};
    o    = tot[31:0] & mask[31:0];
    co   = tot[w];
    ov   = (a[w-1] == bp[w-1]) && (o[w-1] != a[w-1]);
    return {ov & OVF_EN, co, o};
  endfunction

  function automatic logic [17:0] mk(input logic v, input logic c, input logic [15:0] o);
    return {v & OVF_EN, c, o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic s, input logic push, input logic [17:0] e);
    int  n;
    logic acc;
    in_valid = 1'b1; in0 = a; in1 = b; cin = c; sub = s;
    n = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout got stalled exp accepted");
        break;
      end
    end
    if (acc && push) exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q2.size() != 0 || q4.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d left exp 0", exp_q.size() + q2.size() + q4.size());
    end
  endtask

  // Random backpressure source.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitors ----------------
  logic        hold_v = 1'b0;
  logic [17:0] hold_d;

  always @(negedge clk) begin
    logic [17:0] got, e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      got = {ovf, cout, out};
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready got %b exp %b", in_ready, (!out_valid || out_ready));
      end
      if (hold_v) begin
        checks++;
        if (got !== hold_d) begin
          errors++;
          $display("FAIL hold_stable got %h exp %h", got, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h exp none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result got %h exp %h", got, e);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = got;
    end
  end

  always @(negedge clk) begin
    logic [5:0] got, e;
    if (!rst) begin
      checks++;
      if (s2_in_ready !== 1'b1 || s4_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_in_ready got %b%b exp 11", s2_in_ready, s4_in_ready);
      end
      if (s2_out_valid) begin
        got = {s2_ovf, s2_cout, s2_out};
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL s2_unexpected got %h exp none", got);
        end else begin
          e = q2.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL s2_result got %h exp %h", got, e);
          end
        end
      end
      if (s4_out_valid) begin
        got = {s4_ovf, s4_cout, s4_out};
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL s4_unexpected got %h exp none", got);
        end else begin
          e = q4.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL s4_result got %h exp %h", got, e);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [33:0] r;
    logic [15:0] a, b;
    logic        c, s;
    int          lat;
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic add with latency measurement
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 16'h5555));
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    chk("latency", lat, 32'd4);
    @(negedge clk);
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Directed carry / subtract / overflow vectors, back to back
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 16'h0000));
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, mk(1'b0, 1'b1, 16'h0000));
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 16'hFFFE));
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'h0002));
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 16'h0001));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 16'h8000));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 16'h7FFF));
    in_valid = 1'b0;
    drain();

    // Streaming with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      r = ref_model(16, {16'd0, a}, {16'd0, b}, c, s);
      send(a, b, c, s, 1'b1, {r[33], r[32], r[15:0]});
    end
    in_valid = 1'b0;
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-flight: three beats in the pipe are discarded
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, '0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, '0);
    send(16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, '0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out", {16'd0, out}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Exhaustive 4-bit sweep on both small instances
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 4; ic++) begin
          sw_valid = 1'b1;
          sw_a = 4'(ia); sw_b = 4'(ib);
          sw_cin = ic[0]; sw_sub = ic[1];
          r = ref_model(4, 32'(ia), 32'(ib), ic[0], ic[1]);
          q2.push_back({r[33], r[32], r[3:0]});
          q4.push_back({r[33], r[32], r[3:0]});
          @(posedge clk); #1;
        end
      end
    end
    sw_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
